// File: rtl/fast_corner_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : fast_corner_collector_if
//  Description : Pixel-input and corner-output signal bundle for
//                fast_corner_collector. The design uses the slave view and
//                the pixel source / consumer uses the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fast_corner_collector_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic           in_valid;
  logic           is_corner;
  logic           sof;
  logic           out_valid;
  logic           out_ready;
  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;
  logic           frame_done;
  logic [15:0]    frame_corners;
  logic           overflow;

  modport master (
    output in_valid, is_corner, sof, out_ready,
    input  out_valid, out_x, out_y, frame_done, frame_corners, overflow
  );

  modport slave (
    input  in_valid, is_corner, sof, out_ready,
    output out_valid, out_x, out_y, frame_done, frame_corners, overflow
  );
endinterface
`default_nettype wire

// File: rtl/fast_corner_collector.sv
`default_nettype none
// ============================================================================
//  Module      : fast_corner_collector
//  Description : Tracks the raster position of a FAST segment-test stream,
//                queues corner coordinates in a first-word-fall-through FIFO,
//                and reports a per-frame corner count and overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fast_corner_collector #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fast_corner_collector_if.slave bus
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [X_W-1:0] X_LAST   = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(IMG_H - 1);
  localparam logic [AW:0]    FULL_OCC = (AW+1)'(DEPTH);

  // Raster position of the next pixel and the position of the current one.
  logic [X_W-1:0] x_q, x_d, cur_x;
  logic [Y_W-1:0] y_q, y_d, cur_y;
  logic           last_px;

  // FIFO storage: each entry is {y, x}.
  logic [X_W+Y_W-1:0] mem_q [DEPTH];
  logic [X_W+Y_W-1:0] head;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        occ_q, occ_d;
  logic               out_valid;
  logic               push, pop, accept, drop;

  // Per-frame bookkeeping.
  logic [15:0] cnt_q, cnt_base, cnt_d;
  logic [15:0] fc_q;
  logic        fd_q;
  logic        ovf_q, ovf_d;

  // sof forces the current pixel to (0,0); a frame-boundary pixel wraps to (0,0).
  always_comb begin
    cur_x   = bus.sof ? '0 : x_q;
    cur_y   = bus.sof ? '0 : y_q;
    last_px = (cur_x == X_LAST) && (cur_y == Y_LAST);
    x_d     = cur_x + X_W'(1);
    y_d     = cur_y;
    if (last_px) begin
      x_d = '0;
      y_d = '0;
    end else if (cur_x == X_LAST) begin
      x_d = '0;
      y_d = cur_y + Y_W'(1);
    end
  end

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign out_valid = (occ_q != '0);
  assign push      = bus.in_valid && bus.is_corner;
  assign pop       = out_valid && bus.out_ready;
  assign accept    = push && ((occ_q != FULL_OCC) || pop);
  assign drop      = push && !accept;

  // Occupancy next state and per-frame counter / overflow next state.
  always_comb begin
    occ_d = occ_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
    cnt_base = bus.sof ? '0 : cnt_q;
    cnt_d    = (bus.is_corner && (cnt_base != 16'hFFFF)) ? cnt_base + 16'd1 : cnt_base;
    ovf_d    = (bus.sof ? 1'b0 : ovf_q) | drop;
  end

  // Position, corner count, frame-end report and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      fc_q  <= '0;
      fd_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (bus.in_valid) begin
        x_q   <= x_d;
        y_q   <= y_d;
        ovf_q <= ovf_d;
        if (last_px) begin
          fc_q  <= cnt_d;
          cnt_q <= '0;
          fd_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      occ_q <= occ_d;
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // FIFO storage write; contents are only visible through the valid-gated head.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= {cur_y, cur_x};
  end

  assign head              = mem_q[rd_ptr_q];
  assign bus.out_valid     = out_valid;
  assign bus.out_x         = out_valid ? head[X_W-1:0]       : '0;
  assign bus.out_y         = out_valid ? head[X_W+Y_W-1:X_W] : '0;
  assign bus.frame_done    = fd_q;
  assign bus.frame_corners = fc_q;
  assign bus.overflow      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fast_corner_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fast_corner_collector
//  Description : Directed, table-driven bench for fast_corner_collector on a
//                4x2 image with a 4-entry FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fast_corner_collector;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int X_W   = 3;
  localparam int Y_W   = 2;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fast_corner_collector_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  fast_corner_collector #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W), .Y_W(Y_W), .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Inputs for one cycle and the outputs expected just after its rising edge.
  typedef struct {
    logic v, c, s, r;
    logic ov;
    int   x, y;
    logic fd, ovf;
    int   fc;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic v, input logic c, input logic s, input logic r,
                              input logic ov, input int x, input int y,
                              input logic fd, input logic ovf, input int fc);
    vec_t t;
    t.v = v; t.c = c; t.s = s; t.r = r;
    t.ov = ov; t.x = x; t.y = y; t.fd = fd; t.ovf = ovf; t.fc = fc;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic s, input logic r);
    bus.in_valid  = v;
    bus.is_corner = c;
    bus.sof       = s;
    bus.out_ready = r;
  endtask

  task automatic check_outs(input string tag, input vec_t t);
    chk({tag, ".out_valid"}, int'(bus.out_valid), int'(t.ov));
    if (t.ov) begin
      chk({tag, ".out_x"}, int'(bus.out_x), t.x);
      chk({tag, ".out_y"}, int'(bus.out_y), t.y);
    end
    chk({tag, ".frame_done"},    int'(bus.frame_done),    int'(t.fd));
    chk({tag, ".overflow"},      int'(bus.overflow),      int'(t.ovf));
    chk({tag, ".frame_corners"}, int'(bus.frame_corners), t.fc);
  endtask

  task automatic apply(input string tag, input vec_t t);
    drive(t.v, t.c, t.s, t.r);
    @(posedge clk);
    #1;
    check_outs(tag, t);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", mk(0,0,0,0, 0,0,0, 0,0,0));
    chk("reset.out_x", int'(bus.out_x), 0);
    chk("reset.out_y", int'(bus.out_y), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame: corners at pixels 1 and 6, consumer always ready.
    tv.push_back(mk(1,0,1,1, 0,0,0, 0,0,0));
    tv.push_back(mk(1,1,0,1, 1,1,0, 0,0,0));
    tv.push_back(mk(1,0,0,1, 0,0,0, 0,0,0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(1,0,0,1, 0,0,0, 0,0,0));
    tv.push_back(mk(1,1,0,1, 1,2,1, 0,0,0));
    tv.push_back(mk(1,0,0,1, 0,0,0, 1,0,2));
    tv.push_back(mk(0,0,0,1, 0,0,0, 0,0,2));
    // Backpressure: four corners queued with head held, then drained in order.
    tv.push_back(mk(1,1,1,0, 1,0,0, 0,0,2));
    for (int i = 0; i < 3; i++) tv.push_back(mk(1,1,0,0, 1,0,0, 0,0,2));
    tv.push_back(mk(0,0,0,1, 1,1,0, 0,0,2));
    tv.push_back(mk(0,0,0,1, 1,2,0, 0,0,2));
    tv.push_back(mk(0,0,0,1, 1,3,0, 0,0,2));
    tv.push_back(mk(0,0,0,1, 0,0,0, 0,0,2));
    for (int i = 0; i < 3; i++) tv.push_back(mk(1,0,0,1, 0,0,0, 0,0,2));
    tv.push_back(mk(1,0,0,1, 0,0,0, 1,0,4));
    // Overflow: corners on all 8 pixels, consumer stalled.
    tv.push_back(mk(1,1,1,0, 1,0,0, 0,0,4));
    for (int i = 0; i < 3; i++) tv.push_back(mk(1,1,0,0, 1,0,0, 0,0,4));
    for (int i = 0; i < 3; i++) tv.push_back(mk(1,1,0,0, 1,0,0, 0,1,4));
    tv.push_back(mk(1,1,0,0, 1,0,0, 1,1,8));
    tv.push_back(mk(0,0,0,1, 1,1,0, 0,1,8));
    tv.push_back(mk(0,0,0,1, 1,2,0, 0,1,8));
    tv.push_back(mk(0,0,0,1, 1,3,0, 0,1,8));
    tv.push_back(mk(0,0,0,1, 0,0,0, 0,1,8));
    tv.push_back(mk(1,0,1,1, 0,0,0, 0,0,8));

    for (int i = 0; i < tv.size(); i++) apply($sformatf("vec%0d", i), tv[i]);

    // Full FIFO with a simultaneous pop and push: no drop, occupancy stays 4.
    for (int i = 0; i < 4; i++) apply($sformatf("full%0d", i), mk(1,1,0,0, 1,1,0, 0,0,8));
    apply("full_pop_push", mk(1,1,0,1, 1,2,0, 0,0,8));
    apply("full_drop",     mk(1,1,0,0, 1,2,0, 0,1,8));
    apply("full_drain0",   mk(0,0,0,1, 1,3,0, 0,1,8));
    apply("full_drain1",   mk(0,0,0,1, 1,0,1, 0,1,8));
    apply("full_drain2",   mk(0,0,0,1, 1,1,1, 0,1,8));
    apply("full_drain3",   mk(0,0,0,1, 0,0,0, 0,1,8));
    apply("full_end",      mk(1,0,0,1, 0,0,0, 1,1,6));

    // Mid-frame sof at pixel 5 restarts the frame; old frame never completes.
    apply("mid_sof0", mk(1,0,1,1, 0,0,0, 0,0,6));
    for (int i = 1; i < 5; i++) apply($sformatf("mid_px%0d", i), mk(1,0,0,1, 0,0,0, 0,0,6));
    apply("mid_sof", mk(1,1,1,1, 1,0,0, 0,0,6));
    for (int i = 1; i < 7; i++) apply($sformatf("mid_new%0d", i), mk(1,0,0,1, 0,0,0, 0,0,6));
    apply("mid_end", mk(1,0,0,1, 0,0,0, 1,0,1));

    // Reset mid-frame with two entries queued.
    apply("rst_q0", mk(1,1,1,0, 1,0,0, 0,0,1));
    apply("rst_q1", mk(1,1,0,0, 1,0,0, 0,0,1));
    apply("rst_q2", mk(1,0,0,0, 1,0,0, 0,0,1));
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", mk(0,0,0,1, 0,0,0, 0,0,0));
    chk("async_rst.out_x", int'(bus.out_x), 0);
    chk("async_rst.out_y", int'(bus.out_y), 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst0", mk(1,1,0,1, 1,0,0, 0,0,0));
    for (int i = 1; i < 5; i++) apply($sformatf("post_rst%0d", i), mk(1,0,0,1, 0,0,0, 0,0,0));
    apply("post_rst5", mk(1,1,0,1, 1,1,1, 0,0,0));
    apply("post_rst6", mk(1,0,0,1, 0,0,0, 0,0,0));
    apply("post_rst7", mk(1,0,0,1, 0,0,0, 1,0,2));
    apply("post_idle", mk(0,0,0,1, 0,0,0, 0,0,2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
